// File: rtl/vm_pkg.sv
// Types and constants shared by the vending machine datapath: controller states,
// coin select codes and the default coin values the credit/ALU side also uses.
package vm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        ISSUE,
        GAP,
        DONE
    } state_t;

    localparam logic [1:0] COIN_S = 2'd0;
    localparam logic [1:0] COIN_M = 2'd1;
    localparam logic [1:0] COIN_L = 2'd2;

    localparam int DENOM_L_DEFAULT = 50;
    localparam int DENOM_M_DEFAULT = 10;
    localparam int DENOM_S_DEFAULT = 1;

endpackage

// File: rtl/coin_selector.sv
// Greedy denomination picker: the largest coin not exceeding the balance.
// Purely combinational, so the display logic can reuse it to preview change.
module coin_selector
    import vm_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DENOM_L = DENOM_L_DEFAULT,
    parameter int DENOM_M = DENOM_M_DEFAULT,
    parameter int DENOM_S = DENOM_S_DEFAULT
) (
    input  logic [WIDTH-1:0] remaining,
    output logic [1:0]       coin_sel,
    output logic [WIDTH-1:0] denom
);

    localparam logic [WIDTH-1:0] L_VAL = WIDTH'(DENOM_L);
    localparam logic [WIDTH-1:0] M_VAL = WIDTH'(DENOM_M);
    localparam logic [WIDTH-1:0] S_VAL = WIDTH'(DENOM_S);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        coin_sel = COIN_S;
        denom    = S_VAL;
        if (remaining >= L_VAL) begin
            coin_sel = COIN_L;
            denom    = L_VAL;
        end else if (remaining >= M_VAL) begin
            coin_sel = COIN_M;
            denom    = M_VAL;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change-return engine: decomposes a balance greedily into coins and hands them
// one at a time to the coin ejector over a valid/ready handshake.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DENOM_L    = DENOM_L_DEFAULT,
    parameter int DENOM_M    = DENOM_M_DEFAULT,
    parameter int DENOM_S    = DENOM_S_DEFAULT,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] input_amount,
    input  logic             coin_ready,
    output logic             coin_valid,
    output logic [1:0]       coin_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] remaining,
    output logic [WIDTH-1:0] coins_dispensed
);

    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    state_t           state;
    logic [3:0]       gap_cnt;
    logic [1:0]       sel_code;
    logic [WIDTH-1:0] sel_value;

    // remaining is frozen from SELECT through acceptance, so sel_value always
    // matches the registered coin_sel while the coin is pending.
    coin_selector #(
        .WIDTH   (WIDTH),
        .DENOM_L (DENOM_L),
        .DENOM_M (DENOM_M),
        .DENOM_S (DENOM_S)
    ) u_coin_selector (
        .remaining (remaining),
        .coin_sel  (sel_code),
        .denom     (sel_value)
    );

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            gap_cnt         <= '0;
            coin_valid      <= 1'b0;
            coin_sel        <= COIN_S;
            busy            <= 1'b0;
            done            <= 1'b0;
            remaining       <= '0;
            coins_dispensed <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining       <= input_amount;
                        coins_dispensed <= '0;
                        busy            <= 1'b1;
                        if (input_amount == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SELECT;
                        end
                    end
                end
                SELECT: begin
                    coin_sel   <= sel_code;
                    coin_valid <= 1'b1;
                    state      <= ISSUE;
                end
                ISSUE: begin
                    if (coin_ready) begin
                        remaining       <= remaining - sel_value;
                        coins_dispensed <= coins_dispensed + WIDTH'(1);
                        coin_valid      <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            gap_cnt <= GAP_LOAD;
                            state   <= GAP;
                        end else if (remaining == sel_value) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SELECT;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        if (remaining == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SELECT;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: one instance with a one-cycle gap after
// each coin, one with no gap; expected values are hand-computed per scenario.
module tb_change_dispenser;
    import vm_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             start_g0;
    logic             coin_ready;
    logic [WIDTH-1:0] input_amount;

    logic             coin_valid, busy, done;
    logic [1:0]       coin_sel;
    logic [WIDTH-1:0] remaining, coins_dispensed;

    logic             coin_valid_g0, busy_g0, done_g0;
    logic [1:0]       coin_sel_g0;
    logic [WIDTH-1:0] remaining_g0, coins_dispensed_g0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int done_cyc;

    logic [1:0]       sel_q[$];
    logic [WIDTH-1:0] rem_q[$];

    logic [1:0]       t1_sel[7]  = '{2, 1, 0, 0, 0, 0, 0};
    logic [WIDTH-1:0] t1_rem[7]  = '{65, 15, 5, 4, 3, 2, 1};
    logic [1:0]       t6_sel[10] = '{2, 2, 2, 2, 2, 0, 0, 0, 0, 0};
    logic [WIDTH-1:0] t6_rem[10] = '{255, 205, 155, 105, 55, 5, 4, 3, 2, 1};

    change_dispenser #(.WIDTH(WIDTH), .GAP_CYCLES(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .input_amount    (input_amount),
        .coin_ready      (coin_ready),
        .coin_valid      (coin_valid),
        .coin_sel        (coin_sel),
        .busy            (busy),
        .done            (done),
        .remaining       (remaining),
        .coins_dispensed (coins_dispensed)
    );

    change_dispenser #(.WIDTH(WIDTH), .GAP_CYCLES(0)) dut_g0 (
        .clk             (clk),
        .rst             (rst),
        .start           (start_g0),
        .input_amount    (input_amount),
        .coin_ready      (coin_ready),
        .coin_valid      (coin_valid_g0),
        .coin_sel        (coin_sel_g0),
        .busy            (busy_g0),
        .done            (done_g0),
        .remaining       (remaining_g0),
        .coins_dispensed (coins_dispensed_g0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drive start for one edge; that edge is edge 0, so afterwards cyc == 1.
    task automatic launch(input logic [WIDTH-1:0] amt);
        input_amount = amt;
        start        = 1'b1;
        cyc          = 0;
        step();
        start        = 1'b0;
    endtask

    // Step until done, recording each coin accepted on the coming edge.
    task automatic collect(input int budget);
        sel_q.delete();
        rem_q.delete();
        done_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (coin_valid && coin_ready) begin
                sel_q.push_back(coin_sel);
                rem_q.push_back(remaining);
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            step();
        end
        check("done_within_budget", done_cyc >= 0, 1);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        start_g0     = 1'b0;
        coin_ready   = 1'b1;
        input_amount = '0;
        step();
        step();

        check("rst_valid", coin_valid, 0);
        check("rst_sel", coin_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rem", remaining, 0);
        check("rst_coins", coins_dispensed, 0);
        check("rst_g0_busy", busy_g0, 0);
        rst = 1'b0;
        step();

        // 1: 65 with one gap cycle per coin
        launch(8'd65);
        check("t1_c1_busy", busy, 1);
        check("t1_c1_valid", coin_valid, 0);
        check("t1_c1_rem", remaining, 65);
        begin
            int k = 0;
            for (int c = 2; c <= 23; c++) begin
                step();
                check($sformatf("t1_valid_c%0d", c), coin_valid, (c <= 20) && ((c - 2) % 3 == 0));
                if ((c <= 20) && ((c - 2) % 3 == 0)) begin
                    check($sformatf("t1_sel_%0d", k), coin_sel, t1_sel[k]);
                    check($sformatf("t1_rem_%0d", k), remaining, t1_rem[k]);
                    k++;
                end
                check($sformatf("t1_done_c%0d", c), done, c == 22);
                check($sformatf("t1_busy_c%0d", c), busy, c <= 22);
            end
        end
        check("t1_coins", coins_dispensed, 7);
        check("t1_rem_end", remaining, 0);

        // 2: zero amount finishes immediately
        launch(8'd0);
        check("t2_done_c1", done, 1);
        check("t2_valid_c1", coin_valid, 0);
        check("t2_rem", remaining, 0);
        check("t2_coins", coins_dispensed, 0);
        check("t2_busy_c1", busy, 1);
        step();
        check("t2_done_c2", done, 0);
        check("t2_busy_c2", busy, 0);
        check("t2_valid_c2", coin_valid, 0);

        // 3: 60 with the ejector stalled for five cycles
        coin_ready = 1'b0;
        launch(8'd60);
        step();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_stall_valid_%0d", i), coin_valid, 1);
            check($sformatf("t3_stall_sel_%0d", i), coin_sel, 2);
            check($sformatf("t3_stall_rem_%0d", i), remaining, 60);
            if (i < 4) step();
        end
        coin_ready = 1'b1;
        collect(30);
        check("t3_ncoins", sel_q.size(), 2);
        for (int i = 0; i < sel_q.size(); i++) begin
            check($sformatf("t3_sel_%0d", i), sel_q[i], (i == 0) ? 2 : 1);
            check($sformatf("t3_rem_%0d", i), rem_q[i], (i == 0) ? 60 : 10);
        end
        check("t3_done_cyc", done_cyc, 11);
        check("t3_coins", coins_dispensed, 2);
        step();

        // 4: 30 with a second start while busy
        launch(8'd30);
        input_amount = 8'd99;
        start        = 1'b1;
        step();
        start        = 1'b0;
        collect(30);
        check("t4_ncoins", sel_q.size(), 3);
        for (int i = 0; i < sel_q.size(); i++) begin
            check($sformatf("t4_sel_%0d", i), sel_q[i], 1);
            check($sformatf("t4_rem_%0d", i), rem_q[i], 30 - 10 * i);
        end
        check("t4_done_cyc", done_cyc, 10);
        check("t4_rem_end", remaining, 0);
        check("t4_coins", coins_dispensed, 3);
        step();
        check("t4_idle_busy", busy, 0);

        // 5: reset mid-transaction, then a fresh 7
        launch(8'd65);
        repeat (4) step();
        check("t5_c5_valid", coin_valid, 1);
        check("t5_c5_sel", coin_sel, 1);
        check("t5_c5_rem", remaining, 15);
        step();
        check("t5_c6_coins", coins_dispensed, 2);
        check("t5_c6_rem", remaining, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_valid", coin_valid, 0);
        check("t5_rst_sel", coin_sel, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_rem", remaining, 0);
        check("t5_rst_coins", coins_dispensed, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t5_quiet_done_%0d", i), done, 0);
            check($sformatf("t5_quiet_busy_%0d", i), busy, 0);
        end
        launch(8'd7);
        collect(40);
        check("t5_ncoins", sel_q.size(), 7);
        for (int i = 0; i < sel_q.size(); i++) begin
            check($sformatf("t5_sel_%0d", i), sel_q[i], 0);
        end
        check("t5_done_cyc", done_cyc, 22);
        check("t5_coins", coins_dispensed, 7);
        step();

        // 6: 255 with no gap cycles
        input_amount = 8'd255;
        start_g0     = 1'b1;
        cyc          = 0;
        step();
        start_g0     = 1'b0;
        check("t6_c1_busy", busy_g0, 1);
        begin
            int k = 0;
            for (int c = 2; c <= 22; c++) begin
                step();
                check($sformatf("t6_valid_c%0d", c), coin_valid_g0, (c <= 20) && (c % 2 == 0));
                if ((c <= 20) && (c % 2 == 0)) begin
                    check($sformatf("t6_sel_%0d", k), coin_sel_g0, t6_sel[k]);
                    check($sformatf("t6_rem_%0d", k), remaining_g0, t6_rem[k]);
                    k++;
                end
                check($sformatf("t6_done_c%0d", c), done_g0, c == 21);
            end
        end
        check("t6_coins", coins_dispensed_g0, 10);
        check("t6_rem_end", remaining_g0, 0);
        check("t6_busy_end", busy_g0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
